// File: rtl/dco_sdm_ctrl.sv
// Configuration sequencer for the DCO sigma-delta modulator: flush -> load -> settle around every reconfig.
// Optional din slew limiting is compiled in with macro DCO_SDM_CTRL_SLEW_EN.
module dco_sdm_ctrl #(
  parameter int N_DI     = 8,
  parameter int N_MAG    = 3,
  parameter int N_FLUSH  = 4,
  parameter int N_SETTLE = 16,
  parameter int N_STEP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_req,
  output logic             cfg_ack,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_mash,
  input  logic [N_MAG-1:0] cfg_mag,
  input  logic [N_DI-1:0]  frac_in,
  output logic             en_sdm,
  output logic [1:0]       sel_sdm_mash,
  output logic [N_MAG-1:0] prbs_mag,
  output logic [N_DI-1:0]  din,
  output logic             busy,
  output logic             cfg_err
);

  localparam int CNT_MAX = (N_FLUSH > N_SETTLE) ? N_FLUSH : N_SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(N_FLUSH);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(N_SETTLE - 1);
`ifdef DCO_SDM_CTRL_SLEW_EN
  localparam logic [N_DI-1:0] STEP_LIM = N_DI'(N_STEP);
`else
  localparam logic [N_DI-1:0] STEP_LIM = {N_DI{1'b1}};
`endif

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LOAD, S_SETTLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sh_en_q, sh_en_d;
  logic [1:0]       sh_mash_q, sh_mash_d;
  logic [N_MAG-1:0] sh_mag_q, sh_mag_d;
  logic             en_sdm_q, en_sdm_d;
  logic [1:0]       mash_q, mash_d;
  logic [N_MAG-1:0] mag_q, mag_d;
  logic [N_DI-1:0]  din_q, din_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             cfg_err_q, cfg_err_d;
  logic             accept;
  logic             seq_done;

  // Move cur toward tgt by at most STEP_LIM; with the full-range limit this is a plain copy.
  function automatic logic [N_DI-1:0] din_step(input logic [N_DI-1:0] cur,
                                               input logic [N_DI-1:0] tgt);
    logic [N_DI-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > STEP_LIM) ? cur + STEP_LIM : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > STEP_LIM) ? cur - STEP_LIM : tgt;
    end
  endfunction

  assign accept   = ((state_q == S_IDLE) || (state_q == S_RUN)) && cfg_req && !cfg_ack_q;
  assign seq_done = ((state_q == S_LOAD) && !sh_en_q) ||
                    ((state_q == S_SETTLE) && (cnt_q == SETTLE_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_en_q   <= 1'b0;
      sh_mash_q <= '0;
      sh_mag_q  <= '0;
      en_sdm_q  <= 1'b0;
      mash_q    <= '0;
      mag_q     <= '0;
      din_q     <= '0;
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_en_q   <= sh_en_d;
      sh_mash_q <= sh_mash_d;
      sh_mag_q  <= sh_mag_d;
      en_sdm_q  <= en_sdm_d;
      mash_q    <= mash_d;
      mag_q     <= mag_d;
      din_q     <= din_d;
      cfg_ack_q <= cfg_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // FLUSH spends its first cycle dropping en_sdm, then counts N_FLUSH cycles with it low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        state_d = sh_en_q ? S_SETTLE : S_IDLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sh_en_d   = sh_en_q;
    sh_mash_d = sh_mash_q;
    sh_mag_d  = sh_mag_q;
    en_sdm_d  = en_sdm_q;
    mash_d    = mash_q;
    mag_d     = mag_q;
    din_d     = din_q;
    cfg_ack_d = cfg_ack_q;
    cfg_err_d = cfg_err_q;
    busy      = (state_q == S_FLUSH) || (state_q == S_LOAD) || (state_q == S_SETTLE);
    if (accept) begin
      sh_en_d   = cfg_en;
      sh_mash_d = cfg_mash;
      sh_mag_d  = cfg_mag;
    end
    if (state_q == S_FLUSH) en_sdm_d = 1'b0;
    if (state_q == S_LOAD) begin
      en_sdm_d = sh_en_q;
      mash_d   = (sh_mash_q == 2'd3) ? 2'd2 : sh_mash_q;
      mag_d    = sh_mag_q;
      if (sh_mash_q == 2'd3) cfg_err_d = 1'b1;
    end
    if ((state_q == S_SETTLE) || (state_q == S_RUN)) din_d = din_step(din_q, frac_in);
    if (cfg_ack_q && !cfg_req) cfg_ack_d = 1'b0;
    if (seq_done) cfg_ack_d = 1'b1;
  end

  assign cfg_ack      = cfg_ack_q;
  assign en_sdm       = en_sdm_q;
  assign sel_sdm_mash = mash_q;
  assign prbs_mag     = mag_q;
  assign din          = din_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_dco_sdm_ctrl.sv
// Scoreboard bench for dco_sdm_ctrl: a timeline model predicts per-cycle outputs and each ack transaction.
module tb_dco_sdm_ctrl;
  localparam int N_DI = 8, N_MAG = 3, N_FLUSH = 4, N_SETTLE = 16, N_STEP = 2;
  localparam int LAT_EN  = N_FLUSH + N_SETTLE + 2;
  localparam int LAT_DIS = N_FLUSH + 2;

  logic             clk, rst, cfg_req, cfg_ack, cfg_en, en_sdm, busy, cfg_err;
  logic [1:0]       cfg_mash, sel_sdm_mash;
  logic [N_MAG-1:0] cfg_mag, prbs_mag;
  logic [N_DI-1:0]  frac_in, din;

  dco_sdm_ctrl #(.N_DI(N_DI), .N_MAG(N_MAG), .N_FLUSH(N_FLUSH), .N_SETTLE(N_SETTLE), .N_STEP(N_STEP)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_en(cfg_en),
    .cfg_mash(cfg_mash), .cfg_mag(cfg_mag), .frac_in(frac_in), .en_sdm(en_sdm),
    .sel_sdm_mash(sel_sdm_mash), .prbs_mag(prbs_mag), .din(din), .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  typedef struct { int cyc; int en; int mash; int mag; int err; } ack_exp_t;
  typedef struct { int din; int en; int busy; int ack; } cyc_exp_t;
  ack_exp_t ack_sb[$];
  cyc_exp_t cyc_sb[$];

  // Reference model: position in the sequence is just "edges since accept".
  int cyc = 0, seq_k = -1, din_m = 0;
  bit seq_en, mode_run, ack_m, err_m, en_m;
  always @(posedge clk) begin
    bit upd, acc, ack_pre;
    cyc++;
    if (rst) begin
      seq_k = -1; mode_run = 0; ack_m = 0; err_m = 0; din_m = 0; en_m = 0;
      ack_sb.delete();
    end else begin
      ack_pre = ack_m;
      upd = (seq_k < 0 && mode_run) || (seq_en && seq_k >= N_FLUSH + 2);
      acc = (seq_k < 0) && cfg_req && !ack_pre;
      if (ack_m && !cfg_req) ack_m = 0;
      if (seq_k >= 0) begin
        en_m = seq_en && (seq_k >= N_FLUSH + 1);
        if (seq_k == (seq_en ? LAT_EN - 1 : LAT_DIS - 1)) begin
          ack_m = 1; mode_run = seq_en; seq_k = -1;
        end else seq_k++;
      end
      if (upd) begin
`ifdef DCO_SDM_CTRL_SLEW_EN
        if (int'(frac_in) > din_m)
          din_m += (int'(frac_in) - din_m > N_STEP) ? N_STEP : int'(frac_in) - din_m;
        else
          din_m -= (din_m - int'(frac_in) > N_STEP) ? N_STEP : din_m - int'(frac_in);
`else
        din_m = int'(frac_in);
`endif
      end
      if (acc) begin
        ack_exp_t e;
        seq_k = 0; seq_en = cfg_en;
        if (cfg_mash == 2'd3) err_m = 1;
        e.cyc = cyc + (cfg_en ? LAT_EN : LAT_DIS);
        e.en = cfg_en; e.mash = (cfg_mash == 2'd3) ? 2 : int'(cfg_mash);
        e.mag = int'(cfg_mag); e.err = err_m;
        ack_sb.push_back(e);
      end
    end
    cyc_sb.push_back('{din_m, en_m, (seq_k >= 0), ack_m});
  end

  // Monitor: per-cycle outputs and ack-rise transactions.
  bit ack_prev = 0;
  always @(negedge clk) begin
    if (cyc_sb.size() > 0) begin
      cyc_exp_t c;
      c = cyc_sb.pop_front();
      check("din", din, c.din);
      check("en_sdm", en_sdm, c.en);
      check("busy", busy, c.busy);
      check("cfg_ack", cfg_ack, c.ack);
    end
    if (cfg_ack === 1'b1 && !ack_prev) begin
      if (ack_sb.size() == 0) check("ack_unexpected", 1, 0);
      else begin
        ack_exp_t e;
        e = ack_sb.pop_front();
        check("ack_cycle", cyc, e.cyc);
        check("ack_en_sdm", en_sdm, e.en);
        check("ack_mash", sel_sdm_mash, e.mash);
        check("ack_mag", prbs_mag, e.mag);
        check("ack_err", cfg_err, e.err);
      end
    end
    ack_prev = (cfg_ack === 1'b1);
  end

  bit rnd_frac = 0;
  task automatic tick();
    @(negedge clk);
    if (rnd_frac) frac_in = N_DI'($urandom_range(0, 255));
  endtask

  task automatic request(input logic en, input logic [1:0] mash, input logic [N_MAG-1:0] mag);
    int n;
    n = 0;
    while ((busy || cfg_ack) && n < 100) begin tick(); n++; end
    cfg_req = 1; cfg_en = en; cfg_mash = mash; cfg_mag = mag;
    tick();
    cfg_en = 1'($urandom_range(0, 1)); cfg_mash = 2'($urandom_range(0, 3));
    cfg_mag = N_MAG'($urandom_range(0, 7));
    n = 0;
    while (cfg_ack !== 1'b1 && n < 100) begin tick(); n++; end
    check("ack_seen", cfg_ack, 1);
    cfg_req = 0;
    n = 0;
    while (cfg_ack !== 1'b0 && n < 5) begin tick(); n++; end
    check("ack_release", cfg_ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int exp_seq[$];
    rst = 1; cfg_req = 0; cfg_en = 0; cfg_mash = 0; cfg_mag = 0; frac_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_en_sdm", en_sdm, 0);
    check("rst_mash", sel_sdm_mash, 0);
    check("rst_mag", prbs_mag, 0);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ack", cfg_ack, 0);

    rnd_frac = 1;
    request(1'b1, 2'd2, 3'd3);

    // Directed din step from 0 to 9 in RUN.
    rnd_frac = 0; frac_in = 0;
    n = 0;
    while (din !== 0 && n < 200) begin tick(); n++; end
    check("din_zero", din, 0);
    frac_in = 9;
`ifdef DCO_SDM_CTRL_SLEW_EN
    exp_seq = '{2, 4, 6, 8, 9, 9};
`else
    exp_seq = '{9, 9};
`endif
    foreach (exp_seq[i]) begin
      tick();
      check("din_step", din, exp_seq[i]);
    end

    rnd_frac = 1;
    request(1'b0, 2'd1, 3'd6);
    request(1'b1, 2'd3, 3'd2);
    check("err_sticky", cfg_err, 1);
    request(1'b1, 2'd0, 3'd1);
    check("err_kept", cfg_err, 1);

    // Request dropped in FLUSH and re-raised during SETTLE: one sequence only.
    cfg_req = 1; cfg_en = 1; cfg_mash = 2'd1; cfg_mag = 3'd5;
    tick(); tick();
    cfg_req = 0;
    repeat (8) tick();
    cfg_req = 1; cfg_en = 0; cfg_mash = 2'd0; cfg_mag = 3'd0;
    n = 0;
    while (cfg_ack !== 1'b1 && n < 100) begin tick(); n++; end
    check("drop_ack_seen", cfg_ack, 1);
    repeat (3) tick();
    check("drop_ack_held", cfg_ack, 1);
    cfg_req = 0;
    tick(); tick();
    check("drop_ack_clr", cfg_ack, 0);
    repeat (30) tick();
    check("drop_no_second", busy, 0);

    for (int i = 0; i < 6; i++)
      request(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), N_MAG'($urandom_range(0, 7)));

    repeat (3) tick();
    check("sb_drained", ack_sb.size(), 0);
    rst = 1;
    tick(); tick();
    rst = 0;
    check("rst2_err", cfg_err, 0);
    check("rst2_en_sdm", en_sdm, 0);
    check("rst2_din", din, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
